// File: rtl/score_display_seq_if.sv
// Handshake and display bus of the sequential score-to-7-segment converter.
// The master side issues loads; the slave side returns results and display drive.
interface score_display_seq_if #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 3
);
  logic                  load;
  logic [BIN_W-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg_all;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     digit_sel;

  modport master (
    output load, value,
    input  busy, done, overflow, bcd, seg_all, seg, digit_sel
  );

  modport slave (
    input  load, value,
    output busy, done, overflow, bcd, seg_all, seg, digit_sel
  );
endinterface

// File: rtl/score_display_seq.sv
// Iterative double-dabble binary-to-BCD converter with static and scanned
// active-low 7-segment outputs, leading-zero blanking and overflow saturation.
module score_display_seq #(
  parameter int BIN_W    = 11,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               reset,
  score_display_seq_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]           r_state;
  logic [BIN_W-1:0]     r_shift;
  logic [4*DIGITS-1:0]  r_acc;
  logic                 r_sticky;
  logic [CNT_W-1:0]     r_iter;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_ovf;
  logic                 r_done;
  logic [SC_W-1:0]      r_scan_cnt;
  logic [IDX_W-1:0]     r_scan_idx;
  logic [DIGITS-1:0]    r_digit_sel;

  logic [4*DIGITS-1:0]  w_adj;
  logic [4*DIGITS-1:0]  w_acc_next;
  logic [4*DIGITS-1:0]  w_all_nines;
  logic                 w_sticky_next;
  logic                 w_last;
  logic [DIGITS-1:0]    w_lz;
  logic [DIGITS-1:0]    w_blank;
  logic [6:0]           w_seg_arr [DIGITS];
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_scan_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Per-digit add-3 correction ahead of each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
      assign w_all_nines[4*gi +: 4] = 4'd9;
    end
  endgenerate

  assign w_acc_next    = {w_adj[4*DIGITS-2:0], r_shift[BIN_W-1]};
  assign w_sticky_next = r_sticky | w_adj[4*DIGITS-1];
  assign w_last        = (r_iter == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_iter   <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_shift  <= bus.value;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_iter   <= '0;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc    <= w_acc_next;
          r_shift  <= r_shift << 1;
          r_sticky <= w_sticky_next;
          r_iter   <= r_iter + 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_ovf   <= w_sticky_next;
            r_bcd   <= w_sticky_next ? w_all_nines : w_acc_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_CONV);
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd      = r_bcd;

  // w_lz[k]: digit k and every digit above it are zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      if (gi == DIGITS - 1) begin : g_top
        assign w_lz[gi] = (r_bcd[4*gi +: 4] == 4'd0);
      end else begin : g_low
        assign w_lz[gi] = (r_bcd[4*gi +: 4] == 4'd0) && w_lz[gi+1];
      end
      assign w_blank[gi]   = (BLANK_LZ != 0) && (gi != 0) && w_lz[gi];
      assign w_seg_arr[gi] = w_blank[gi] ? 7'b1111111 : seg7(r_bcd[4*gi +: 4]);
      assign bus.seg_all[7*gi +: 7] = w_seg_arr[gi];
    end
  endgenerate

  assign w_scan_wrap = (r_scan_cnt == SC_W'(SCAN_DIV - 1));
  assign w_idx_next  = (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_scan_idx + 1'b1);

  // Scanning is free-running and independent of the conversion engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_digit_sel <= ~DIGITS'(1);
    end else if (w_scan_wrap) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= w_idx_next;
      r_digit_sel <= ~(DIGITS'(1) << w_idx_next);
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  assign bus.digit_sel = r_digit_sel;
  assign bus.seg       = w_seg_arr[r_scan_idx];

endmodule

// File: doc/score_display_seq.md
Name: score_display_seq

Overview:
- Parametrised, sequential successor to the fixed three-digit score-to-7-segment converter in the bowling score path.
- Converts a BIN_W-bit binary score to DIGITS BCD digits using an iterative double-dabble engine with a load/busy/done handshake.
- Drives a static per-digit segment bus and a time-multiplexed scanned display port, with optional leading-zero blanking and overflow saturation.

Parameters:
- BIN_W, 11: width of the binary input score.
- DIGITS, 3: number of decimal digits; must be at least 1.
- SCAN_DIV, 1024: clock cycles each digit is held on the scanned port; must be at least 1.
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows every digit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  start a conversion of value; sampled only while busy=0.
- value  input  BIN_W  binary score to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd, seg_all and overflow update.
- overflow  output  1  latched result: value did not fit in DIGITS digits.
- bcd  output  4*DIGITS  latched result; digit k is at [4k+3:4k], k=0 is the units digit.
- seg_all  output  7*DIGITS  static segments, active-low; field k is at [7k+6:7k], MSB=a ... LSB=g.
- seg  output  7  segments of the currently scanned digit; same encoding as seg_all.
- digit_sel  output  DIGITS  active-low one-hot enable for the scanned digit.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE; busy=0, done=0, overflow=0, bcd=0.
  - Scan counter=0, scan index=0, so digit_sel = all ones except bit0=0.
  - Any conversion in flight is aborted and its result is discarded.
- FSM states: IDLE and CONV.
- IDLE, load=1 at a clock edge:
  - Capture value into the shift register.
  - Clear the BCD accumulator and the sticky overflow flag; set iteration counter=0.
  - Go to CONV; busy=1 from the next cycle.
- IDLE, load=0: hold all state.
- CONV, each edge:
  - Add 3 to every accumulator digit that is >=5.
  - Shift {accumulator, shift register} left by 1.
  - If the bit shifted out of the accumulator MSB is 1, set the sticky overflow flag.
  - Increment the iteration counter.
- CONV, on the edge completing iteration BIN_W:
  - Go to IDLE and set busy=0.
  - Pulse done=1 for exactly one cycle.
  - bcd gets the accumulator, or all digits = 9 if the sticky flag is set; overflow gets the sticky flag.
- Latency: load is sampled at edge 0; done is high for the cycle after edge BIN_W. A new load is accepted in that same done cycle.
- load while busy=1 is ignored and is not queued. value need only be stable on the edge where load is accepted.
- bcd, overflow and seg_all hold their previous results throughout a conversion.
- Segment decode (pure function of the bcd register):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Blank=1111111. A digit above 9 cannot occur; decode it as blank.
- Blanking with BLANK_LZ=1:
  - Digit k>0 is blank when it and every digit above it are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - On overflow no digit is blanked, since all digits are 9.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the scan index advances k to k+1, and from DIGITS-1 back to 0.
  - digit_sel is registered: bit k=0 only.
  - seg = field k of seg_all, combinational from the registered index.
  - Scanning runs independently of the FSM and of busy.
- Width rules: the iteration counter is clog2(BIN_W+1) bits; the scan counter is clog2(SCAN_DIV) bits, minimum 1.

Test Plan (BIN_W=11, DIGITS=3, SCAN_DIV=4 unless stated):
- load=1 with value=123 for one cycle -> busy high 11 cycles; done pulse after edge 11; bcd=0x123, overflow=0; seg_all fields 2/1/0 = 1001111/0010010/0000110.
- value=12 -> bcd=0x012, field2 blank (1111111), field1 "1"; value=2 -> fields 2,1 blank, field0 "2"; value=0 -> field0 "0", others blank; with BLANK_LZ=0, value=12 -> field2 "0".
- value=2047 -> overflow=1, bcd=0x999, all fields 0000100; then value=100 -> overflow=0, bcd=0x100, no blanking.
- load 99, then at cycle 5 load 500 -> second load ignored, result 0x099; load in the done cycle is accepted and done recurs 11 edges later.
- Assert reset at cycle 6 of converting 456, release, then load 78 -> after reset all outputs are at reset values; the next result is 0x078 with no trace of 456.
- After bcd=0x123, run 24 cycles -> digit_sel sequence 110,101,011 repeating every 4 cycles; seg equals the matching field each cycle; unchanged during a following conversion.
